// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register owner and sequential-multiplier sequencer
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   hilo_opE            E-stage HI/LO op (none/MULT/MULTU/MFHI/MFLO/MTHI/MTLO)
//   srcaE, srcbE        rs / rt operands
//   hilo_stall          combinational interlock holding the E-stage instruction
//   hilo_resultE        MFHI/MFLO read data, 0 otherwise
//   multE, is_signed,
//   mult_a, mult_b      launch interface to the 64-cycle multiplier
//   mult_stall, mult_s  multiplier busy flag and 64-bit product
//   hi, lo              architectural HI/LO registers
//   hilo_busy           high whenever the sequencer is not IDLE
module hilo_unit #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  hilo_opE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    output logic        hilo_stall,
    output logic [31:0] hilo_resultE,
    output logic        multE,
    output logic        is_signed,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    input  logic        mult_stall,
    input  logic [63:0] mult_s,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        hilo_busy
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MFHI  = 3'b011;
    localparam logic [2:0] OP_MFLO  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic op_active;
    logic op_mult;
    logic op_mf;

    // 000 and the reserved 111 encoding both behave as "no op".
    assign op_active = (hilo_opE != 3'b000) && (hilo_opE != 3'b111);
    assign op_mult   = (hilo_opE == OP_MULT) || (hilo_opE == OP_MULTU);
    assign op_mf     = (hilo_opE == OP_MFHI) || (hilo_opE == OP_MFLO);

    assign mult_a    = srcaE;
    assign mult_b    = srcbE;
    assign is_signed = (hilo_opE == OP_MULT);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign hilo_busy = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        multE        = 1'b0;
        hilo_stall   = 1'b0;
        hilo_resultE = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (op_mult) begin
                    multE   = 1'b1;
                    state_d = S_WAIT;
                end else if (hilo_opE == OP_MTHI) begin
                    hi_d = srcaE;
                end else if (hilo_opE == OP_MTLO) begin
                    lo_d = srcaE;
                end else if (hilo_opE == OP_MFHI) begin
                    hilo_resultE = hi_q;
                end else if (hilo_opE == OP_MFLO) begin
                    hilo_resultE = lo_q;
                end
            end
            S_WAIT: begin
                // multE stays low here: a held launch would retrigger the
                // multiplier the moment its internal busy clears.
                if (mult_stall) begin
                    hilo_stall = op_active;
                end else begin
                    hi_d    = mult_s[63:32];
                    lo_d    = mult_s[31:0];
                    state_d = S_IDLE;
                    if (op_mf && FWD_EN) begin
                        hilo_resultE = (hilo_opE == OP_MFHI) ? mult_s[63:32] : mult_s[31:0];
                    end else begin
                        hilo_stall = op_active;
                    end
                end
            end
            S_DRAIN: begin
                // Multiplier may still be running an op launched before reset;
                // wait for it to go quiet and discard its product.
                hilo_stall = op_active;
                if (!mult_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                hilo_stall = op_active;
                state_d    = S_DRAIN;
            end
        endcase

        if (reset) begin
            multE        = 1'b0;
            hilo_stall   = 1'b1;
            hilo_resultE = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_DRAIN;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed bench for hilo_unit with a 64-cycle multiplier model
module tb_hilo_unit;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MFHI  = 3'b011;
    localparam logic [2:0] OP_MFLO  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  hilo_opE;
    logic [31:0] srcaE, srcbE;

    logic        f_stall, f_multE, f_sgn, f_busy;
    logic [31:0] f_res, f_a, f_b, f_hi, f_lo;
    logic        n_stall, n_multE, n_sgn, n_busy;
    logic [31:0] n_res, n_a, n_b, n_hi, n_lo;

    logic        mult_stall;
    logic [63:0] mult_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hilo_unit #(.FWD_EN(1'b1)) u_fwd (
        .clk(clk), .reset(reset), .hilo_opE(hilo_opE), .srcaE(srcaE), .srcbE(srcbE),
        .hilo_stall(f_stall), .hilo_resultE(f_res), .multE(f_multE), .is_signed(f_sgn),
        .mult_a(f_a), .mult_b(f_b), .mult_stall(mult_stall), .mult_s(mult_s),
        .hi(f_hi), .lo(f_lo), .hilo_busy(f_busy)
    );

    // Same stimulus; only MFHI/MFLO in the completion cycle behaves differently,
    // and those never launch, so both instances share the one multiplier model.
    hilo_unit #(.FWD_EN(1'b0)) u_nf (
        .clk(clk), .reset(reset), .hilo_opE(hilo_opE), .srcaE(srcaE), .srcbE(srcbE),
        .hilo_stall(n_stall), .hilo_resultE(n_res), .multE(n_multE), .is_signed(n_sgn),
        .mult_a(n_a), .mult_b(n_b), .mult_stall(mult_stall), .mult_s(mult_s),
        .hi(n_hi), .lo(n_lo), .hilo_busy(n_busy)
    );

    // Multiplier model: launch in cycle N, stall N..N+64, product in N+65,
    // accepts a new launch from N+66. Not reset, so in-flight ops survive reset.
    logic [6:0]  mcnt = 7'd0;
    logic [31:0] ma = 32'h0, mb = 32'h0;
    logic        msg = 1'b0;

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic sg);
        logic [63:0] ea, eb;
        ea = sg ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sg ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    always @(posedge clk) begin
        if (mcnt == 7'd0) begin
            if (f_multE) begin
                mcnt <= 7'd1;
                ma   <= f_a;
                mb   <= f_b;
                msg  <= f_sgn;
            end
        end else if (mcnt == 7'd65) begin
            mcnt <= 7'd0;
        end else begin
            mcnt <= mcnt + 7'd1;
        end
    end

    assign mult_stall = f_multE || (mcnt >= 7'd1 && mcnt <= 7'd64);
    assign mult_s     = (mcnt >= 7'd1 && mcnt <= 7'd64) ? 64'hDEAD_BEEF_DEAD_BEEF : prod(ma, mb, msg);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        hilo_opE = op;
        srcaE    = a;
        srcbE    = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(OP_NONE, 32'h0, 32'h0);
        step();
        step();
        @(negedge clk);
        checks++; if (f_stall !== 1'b1) begin failures++; $display("FAIL rst_stall got=%b exp=1", f_stall); end
        checks++; if (f_multE !== 1'b0) begin failures++; $display("FAIL rst_multE got=%b exp=0", f_multE); end
        checks++; if (f_hi !== 32'h0 || f_lo !== 32'h0) begin failures++; $display("FAIL rst_hilo got=%h_%h exp=0_0", f_hi, f_lo); end
        checks++; if (f_busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", f_busy); end
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (f_busy !== 1'b1) begin failures++; $display("FAIL rst_drain got=%b exp=1", f_busy); end
        step();
        @(negedge clk);
        checks++; if (f_busy !== 1'b0 || n_busy !== 1'b0) begin failures++; $display("FAIL rst_idle got=%b/%b exp=0", f_busy, n_busy); end
    endtask

    task automatic test_mult(input logic [2:0] op, input logic exp_sg, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int bad;
        drive(op, 32'hFFFF_FFFF, 32'h0000_0002);
        @(negedge clk);
        checks++; if (f_multE !== 1'b1 || f_stall !== 1'b0) begin failures++; $display("FAIL mult_launch op=%0d multE=%b stall=%b exp=1/0", op, f_multE, f_stall); end
        checks++; if (f_sgn !== exp_sg) begin failures++; $display("FAIL mult_sign op=%0d got=%b exp=%b", op, f_sgn, exp_sg); end
        checks++; if (f_a !== 32'hFFFF_FFFF || f_b !== 32'h2) begin failures++; $display("FAIL mult_ab got=%h/%h exp=ffffffff/2", f_a, f_b); end
        step();
        drive(OP_NONE, 32'h0, 32'h0);
        bad = 0;
        for (int c = 1; c <= 65; c++) begin
            @(negedge clk);
            if (f_multE !== 1'b0 || f_busy !== 1'b1) bad++;
            step();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL mult_wait op=%0d bad_cycles=%0d exp=0", op, bad); end
        @(negedge clk);
        checks++; if (f_hi !== exp_hi || f_lo !== exp_lo) begin failures++; $display("FAIL mult_result op=%0d got=%h_%h exp=%h_%h", op, f_hi, f_lo, exp_hi, exp_lo); end
        checks++; if (n_hi !== exp_hi || n_lo !== exp_lo) begin failures++; $display("FAIL mult_result_nf op=%0d got=%h_%h exp=%h_%h", op, n_hi, n_lo, exp_hi, exp_lo); end
        checks++; if (f_busy !== 1'b0) begin failures++; $display("FAIL mult_idle got=%b exp=0", f_busy); end
    endtask

    task automatic test_read_after_mult();
        int bad;
        drive(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        step();
        drive(OP_MFHI, 32'h0, 32'h0);
        bad = 0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (f_stall !== 1'b1 || n_stall !== 1'b1 || f_res !== 32'h0 || n_res !== 32'h0) bad++;
            step();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL raw_stall bad_cycles=%0d exp=0", bad); end
        @(negedge clk);
        checks++; if (f_stall !== 1'b0 || f_res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL raw_fwd stall=%b res=%h exp=0/ffffffff", f_stall, f_res); end
        checks++; if (n_stall !== 1'b1 || n_res !== 32'h0) begin failures++; $display("FAIL raw_nofwd65 stall=%b res=%h exp=1/0", n_stall, n_res); end
        step();
        @(negedge clk);
        checks++; if (n_stall !== 1'b0 || n_res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL raw_nofwd66 stall=%b res=%h exp=0/ffffffff", n_stall, n_res); end
        step();
        drive(OP_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (f_res !== 32'hFFFF_FFFE || f_stall !== 1'b0) begin failures++; $display("FAIL raw_mflo res=%h stall=%b exp=fffffffe/0", f_res, f_stall); end
        step();
        drive(OP_NONE, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        int bad;
        drive(OP_MULT, 32'd3, 32'd5);
        step();
        drive(OP_MULT, 32'd7, 32'd9);
        bad = 0;
        for (int c = 1; c <= 65; c++) begin
            @(negedge clk);
            if (f_stall !== 1'b1 || f_multE !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL b2b_stall bad_cycles=%0d exp=0", bad); end
        @(negedge clk);
        checks++; if (f_stall !== 1'b0 || f_multE !== 1'b1 || mult_stall !== 1'b1) begin failures++; $display("FAIL b2b_launch2 stall=%b multE=%b mstall=%b exp=0/1/1", f_stall, f_multE, mult_stall); end
        checks++; if (f_hi !== 32'h0 || f_lo !== 32'hF) begin failures++; $display("FAIL b2b_first got=%h_%h exp=0_f", f_hi, f_lo); end
        step();
        drive(OP_NONE, 32'h0, 32'h0);
        for (int c = 67; c <= 131; c++) step();
        @(negedge clk);
        checks++; if (f_hi !== 32'h0 || f_lo !== 32'h3F) begin failures++; $display("FAIL b2b_second got=%h_%h exp=0_3f", f_hi, f_lo); end
    endtask

    task automatic test_move_ops();
        int bad;
        drive(OP_MTHI, 32'h1234_5678, 32'h0);
        @(negedge clk);
        checks++; if (f_stall !== 1'b0 || f_multE !== 1'b0) begin failures++; $display("FAIL mthi_stall stall=%b multE=%b exp=0/0", f_stall, f_multE); end
        step();
        drive(OP_MTLO, 32'h9ABC_DEF0, 32'h0);
        @(negedge clk);
        checks++; if (f_stall !== 1'b0 || f_hi !== 32'h1234_5678) begin failures++; $display("FAIL mtlo_stall stall=%b hi=%h exp=0/12345678", f_stall, f_hi); end
        step();
        drive(OP_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (f_stall !== 1'b0 || f_res !== 32'h1234_5678 || n_res !== 32'h1234_5678) begin failures++; $display("FAIL mfhi_read res=%h/%h stall=%b exp=12345678", f_res, n_res, f_stall); end
        step();
        drive(OP_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (f_stall !== 1'b0 || f_res !== 32'h9ABC_DEF0) begin failures++; $display("FAIL mflo_read res=%h stall=%b exp=9abcdef0", f_res, f_stall); end
        step();
        drive(OP_RSVD, 32'hAAAA_AAAA, 32'h0);
        @(negedge clk);
        checks++; if (f_stall !== 1'b0 || f_multE !== 1'b0 || f_res !== 32'h0) begin failures++; $display("FAIL rsvd_op stall=%b multE=%b res=%h exp=0/0/0", f_stall, f_multE, f_res); end
        step();
        @(negedge clk);
        checks++; if (f_hi !== 32'h1234_5678 || f_lo !== 32'h9ABC_DEF0) begin failures++; $display("FAIL rsvd_nowrite got=%h_%h exp=12345678_9abcdef0", f_hi, f_lo); end
        // MULT at local cycle 0, then MTLO held through the multiply.
        drive(OP_MULT, 32'd3, 32'd5);
        step();
        drive(OP_MTLO, 32'h55AA_55AA, 32'h0);
        bad = 0;
        for (int c = 1; c <= 65; c++) begin
            @(negedge clk);
            if (f_stall !== 1'b1) bad++;
            step();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL mtlo_wait bad_cycles=%0d exp=0", bad); end
        @(negedge clk);
        checks++; if (f_stall !== 1'b0 || f_lo !== 32'hF) begin failures++; $display("FAIL mtlo_release stall=%b lo=%h exp=0/f", f_stall, f_lo); end
        step();
        drive(OP_NONE, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (f_hi !== 32'h0 || f_lo !== 32'h55AA_55AA) begin failures++; $display("FAIL mtlo_overwrite got=%h_%h exp=0_55aa55aa", f_hi, f_lo); end
    endtask

    task automatic test_reset_mid_op();
        int bad;
        drive(OP_MULT, 32'd3, 32'd5);
        step();
        drive(OP_NONE, 32'h0, 32'h0);
        for (int c = 1; c <= 19; c++) step();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (f_stall !== 1'b1 || f_multE !== 1'b0) begin failures++; $display("FAIL rmid_during stall=%b multE=%b exp=1/0", f_stall, f_multE); end
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (f_hi !== 32'h0 || f_lo !== 32'h0 || f_busy !== 1'b1) begin failures++; $display("FAIL rmid_after hilo=%h_%h busy=%b exp=0_0/1", f_hi, f_lo, f_busy); end
        step();
        drive(OP_MULT, 32'd7, 32'd9);
        bad = 0;
        for (int c = 22; c <= 65; c++) begin
            @(negedge clk);
            if (f_stall !== 1'b1 || f_multE !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rmid_drain bad_cycles=%0d exp=0", bad); end
        @(negedge clk);
        checks++; if (f_stall !== 1'b0 || f_multE !== 1'b1) begin failures++; $display("FAIL rmid_launch stall=%b multE=%b exp=0/1", f_stall, f_multE); end
        checks++; if (f_hi !== 32'h0 || f_lo !== 32'h0) begin failures++; $display("FAIL rmid_stale got=%h_%h exp=0_0", f_hi, f_lo); end
        step();
        drive(OP_NONE, 32'h0, 32'h0);
        for (int c = 67; c <= 131; c++) step();
        @(negedge clk);
        checks++; if (f_hi !== 32'h0 || f_lo !== 32'h3F) begin failures++; $display("FAIL rmid_result got=%h_%h exp=0_3f", f_hi, f_lo); end
    endtask

    initial begin
        reset = 1'b1;
        drive(OP_NONE, 32'h0, 32'h0);
        test_reset();
        step();
        test_mult(OP_MULT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        step();
        test_mult(OP_MULTU, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
        step();
        test_read_after_mult();
        step();
        test_back_to_back();
        step();
        test_move_ops();
        step();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Execute-stage owner of the HI/LO architectural registers.
- Sits between the pipeline (hilo_opE, srcaE, srcbE) and the 64-cycle sequential multiplier, which it drives through multE/is_signed/a/b and whose mult_stall/s outputs it consumes.
- Launches MULT/MULTU, tracks completion, captures the 64-bit product into HI/LO, and services MFHI/MFLO/MTHI/MTLO.
- Generates the pipeline interlock.

Parameters:
- FWD_EN, 1, when 1 MFHI/MFLO in the completion cycle return the forwarded product instead of stalling.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- hilo_opE  in  3  000 none, 001 MULT, 010 MULTU, 011 MFHI, 100 MFLO, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
- srcaE  in  32  rs operand; MULT multiplicand; MTHI/MTLO data.
- srcbE  in  32  rt operand; multiplier.
- hilo_stall  out  1  combinational; holds the E-stage instruction.
- hilo_resultE  out  32  MFHI/MFLO read data; 0 for other ops.
- multE  out  1  one-cycle launch pulse to the multiplier.
- is_signed  out  1  1 for MULT, 0 for MULTU.
- mult_a  out  32  equals srcaE.
- mult_b  out  32  equals srcbE.
- mult_stall  in  1  multiplier busy/stall output.
- mult_s  in  64  multiplier product, valid once mult_stall falls.
- hi  out  32  HI register.
- lo  out  32  LO register.
- hilo_busy  out  1  state != IDLE.

Behaviour:
- Reset values: hi=0, lo=0, state=DRAIN.
- While reset is high: multE=0, hilo_stall=1, no HI/LO writes.

FSM states: IDLE, WAIT, DRAIN.
- IDLE + MULT/MULTU:
  - multE=1 combinationally, is_signed per op; multiplier samples a/b at this edge.
  - hilo_stall=0, so the MULT retires.
  - Next state WAIT.
- IDLE + MTHI/MTLO: hi (resp. lo) <= srcaE at the edge; no stall.
- IDLE + MFHI/MFLO: hilo_resultE = hi/lo combinationally; no stall.
- WAIT:
  - multE=0, always. A held multE would retrigger the multiplier when its busy clears.
  - mult_stall=1: any non-none op gets hilo_stall=1.
  - mult_stall=0 (completion cycle):
    - {hi,lo} <= mult_s at the edge; next state IDLE.
    - MFHI/MFLO: with FWD_EN=1, hilo_resultE = mult_s[63:32] / mult_s[31:0] and no stall. With FWD_EN=0, stall.
    - MULT/MULTU/MTHI/MTLO: stall.
- DRAIN:
  - Entered from reset because multiplier state is unknown.
  - multE=0; all non-none ops stall; HI/LO not written.
  - Exit to IDLE at the first edge where mult_stall=0.
- Multiplier timing contract:
  - Launch in cycle N: mult_stall=1 for cycles N..N+64, product valid in N+65, internal busy clear from N+66.
  - Exiting WAIT/DRAIN only after observing mult_stall=0 guarantees the next launch (at earliest N+66) is accepted.
- Simultaneous events: reset dominates everything. An op presented while stalled is re-evaluated each cycle, with no queuing.
- MULT/MULTU result is signed/unsigned 64-bit per the multiplier; no width conversion beyond the split HI=[63:32], LO=[31:0].
- hilo_resultE=0 whenever the op is not MFHI/MFLO or the op is stalled.

Test Plan:
- Signed: MULT srcaE=0xFFFFFFFF, srcbE=0x00000002 at cycle 0:
  - multE=1 only in cycle 0, is_signed=1.
  - Cycle 66: hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- Unsigned: same operands with MULTU -> hi=0x00000001, lo=0xFFFFFFFE; is_signed=0.
- Read-after-mult:
  - MFHI presented from cycle 1 -> hilo_stall=1 cycles 1..64.
  - FWD_EN=1: cycle 65 no stall, result = mult_s[63:32].
  - FWD_EN=0: stall through 65, read 0xFFFFFFFF in cycle 66.
- Back-to-back: MULT 3*5 then MULT 7*9 presented from cycle 1:
  - Second stalls until cycle 66, launches there (mult_stall=1 in 66).
  - Final hi=0, lo=0x3F; the first result is lo=0xF at cycle 66.
- Move ops:
  - IDLE MTHI 0x12345678, then MTLO 0x9ABCDEF0, then MFHI, MFLO -> reads 0x12345678, 0x9ABCDEF0, no stalls.
  - MTLO during WAIT stalls until completion; afterwards lo = MTLO data, overwriting the product.
- Reset mid-op:
  - MULT at cycle 0; reset pulse in cycle 20 -> hi=lo=0, state DRAIN.
  - MULT presented cycle 22 stalls until DRAIN exits at edge after cycle 65, launches cycle 66.
  - Stale product never written to HI/LO.
